// File: rtl/cnn_host_loader.sv
`default_nettype none
// ============================================================================
// Module   : cnn_host_loader
// Purpose  : Host-side writer for the CNN accelerator. Words written by the
//            HPS over an Avalon-MM slave are buffered in an ingress FIFO and
//            streamed to the CNN as cnn_load/cnn_data_in. A one-cycle
//            cnn_start pulse follows the last word. The result presented on
//            cnn_data_out with cnn_done is captured for host readback.
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            chipselect, write,  Avalon-MM slave (registered readdata,
//            read, address,      one cycle read latency)
//            writedata, readdata
//            irq                 level, high while DONE is set
//            cnn_load,           registered word stream to the CNN
//            cnn_data_in
//            cnn_start           one-cycle start pulse
//            cnn_done,           result handshake from the CNN
//            cnn_data_out
// Registers: 0 W DATA   push word into FIFO
//            1 W CTRL   bit0 GO, bit1 CLR (clears DONE and OVF)
//            2 R STATUS bit0 BUSY, bit1 DONE, bit2 OVF, bit3 EMPTY, bit4 FULL
//            3 R RESULT last captured cnn_data_out
//            4 R COUNT  words streamed in current/last run
// Revision : 1.0  initial release
// ============================================================================
module cnn_host_loader #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int LOAD_WORDS = 784
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [2:0]        address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              irq,
  output logic              cnn_load,
  output logic [DATA_W-1:0] cnn_data_in,
  output logic              cnn_start,
  input  logic              cnn_done,
  input  logic [DATA_W-1:0] cnn_data_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(LOAD_WORDS + 1);
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(LOAD_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] result;
  logic              done_flag;
  logic              ovf_flag;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic bus_wr;
  logic bus_rd;
  logic push_req;
  logic ctrl_wr;
  logic go;
  logic clr;

  assign bus_wr   = chipselect & write;
  assign bus_rd   = chipselect & read;
  assign push_req = bus_wr && (address == 3'd0);
  assign ctrl_wr  = bus_wr && (address == 3'd1);
  assign go       = ctrl_wr & writedata[0];
  assign clr      = ctrl_wr & writedata[1];

  // --------------------------------------------------------------------------
  // Ingress FIFO
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       level;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push;
  logic              drop;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == FULL_LEVEL);
  // The loader drains one word per cycle whenever it is streaming and data
  // is available; the FSM leaves LOAD on the final pop, so no count guard.
  assign pop        = (state == S_LOAD) && !fifo_empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + (AW + 1)'(1);
      else if (pop && !push) level <= level - (AW + 1)'(1);
    end
  end

  // Storage carries no reset: contents are meaningless while level is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= writedata;
  end

  // --------------------------------------------------------------------------
  // Run control FSM with registered CNN-side outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      count       <= '0;
      result      <= '0;
      cnn_load    <= 1'b0;
      cnn_data_in <= '0;
      cnn_start   <= 1'b0;
    end else begin
      cnn_load  <= 1'b0;
      cnn_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            state <= S_LOAD;
            count <= '0;
          end
        end
        S_LOAD: begin
          // On an empty FIFO cnn_load drops and cnn_data_in keeps its value.
          if (pop) begin
            cnn_load    <= 1'b1;
            cnn_data_in <= mem[rd_ptr];
            count       <= count + CW'(1);
            if (count == LAST_COUNT) state <= S_START;
          end
        end
        S_START: begin
          cnn_start <= 1'b1;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (cnn_done) begin
            result <= cnn_data_out;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky flags; a capture wins over a CLR issued in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_flag <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      if ((state == S_WAIT) && cnn_done) done_flag <= 1'b1;
      else if (clr)                      done_flag <= 1'b0;

      if (drop)     ovf_flag <= 1'b1;
      else if (clr) ovf_flag <= 1'b0;
    end
  end

  assign irq = done_flag;

  // --------------------------------------------------------------------------
  // Register readback
  // --------------------------------------------------------------------------
  logic              busy;
  logic [DATA_W-1:0] status_word;
  logic [DATA_W-1:0] count_word;

  assign busy        = (state != S_IDLE);
  assign status_word = {{(DATA_W - 5){1'b0}}, fifo_full, fifo_empty,
                        ovf_flag, done_flag, busy};
  assign count_word  = DATA_W'(count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readdata <= '0;
    end else if (bus_rd) begin
      case (address)
        3'd2:    readdata <= status_word;
        3'd3:    readdata <= result;
        3'd4:    readdata <= count_word;
        default: readdata <= '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cnn_host_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_host_loader
// Purpose  : Self-checking bench for cnn_host_loader. A register-access
//            vector table plus directed run sequences with random payloads.
//            The reference model keeps the expected word stream in a queue
//            and derives STATUS/RESULT/COUNT from the register-map rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_cnn_host_loader;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int NW    = 784;

  logic          clk;
  logic          rst_n;
  logic          chipselect;
  logic          write;
  logic          read;
  logic [2:0]    address;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;
  logic          irq;
  logic          cnn_load;
  logic [DW-1:0] cnn_data_in;
  logic          cnn_start;
  logic          cnn_done;
  logic [DW-1:0] cnn_data_out;

  cnn_host_loader #(
    .DATA_W    (DW),
    .FIFO_DEPTH(DEPTH),
    .LOAD_WORDS(NW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .chipselect  (chipselect),
    .write       (write),
    .read        (read),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .irq         (irq),
    .cnn_load    (cnn_load),
    .cnn_data_in (cnn_data_in),
    .cnn_start   (cnn_start),
    .cnn_done    (cnn_done),
    .cnn_data_out(cnn_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] exp_q[$];     // words accepted but not yet seen on cnn_data_in
  bit            m_done;
  bit            m_ovf;
  logic [DW-1:0] m_result;
  int            loads_run;
  int            starts;
  bit            trickle;
  bit            prev_load;

  typedef struct {
    bit            is_wr;
    logic [2:0]    a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_status(input bit busy);
    return {11'b0, exp_q.size() == DEPTH, exp_q.size() == 0, m_ovf, m_done, busy};
  endfunction

  // Stream monitor: every load must be the next accepted word, at most NW per run.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cnn_load) begin
        if (exp_q.size() == 0 || loads_run >= NW) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load actual=0x%0h loads=%0d required=no_load", cnn_data_in, loads_run);
        end else begin
          logic [DW-1:0] w;
          w = exp_q.pop_front();
          check("load_data", cnn_data_in, w);
          loads_run++;
        end
        if (trickle && prev_load) begin
          checks++;
          errors++;
          $display("FAIL trickle_gap actual=back_to_back_load required=gap");
        end
      end
      if (cnn_start) starts++;
      prev_load = cnn_load;
    end else begin
      prev_load = 1'b0;
    end
  end

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [2:0] a, input logic [DW-1:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [DW-1:0] d);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    @(negedge clk);
    chipselect = 1'b0;
    read       = 1'b0;
    d          = readdata;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [DW-1:0] exp);
    logic [DW-1:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  // Pushes issued while IDLE follow the capacity rule; while streaming the
  // stimulus never outruns the drain, so every word is accepted.
  task automatic push_word(input logic [DW-1:0] w, input bit idle);
    if (idle && exp_q.size() >= DEPTH) m_ovf = 1'b1;
    else                               exp_q.push_back(w);
    bus_write(3'd0, w);
  endtask

  task automatic go_run();
    loads_run = 0;
    bus_write(3'd1, 16'h0001);
  endtask

  task automatic pulse_done(input logic [DW-1:0] v);
    cnn_done     = 1'b1;
    cnn_data_out = v;
    @(negedge clk);
    cnn_done     = 1'b0;
  endtask

  task automatic wait_run(input string tag, input int s0);
    int n;
    n = 0;
    while (starts == s0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start_seen"}, 32'(starts != s0), 1);
    @(negedge clk);
    check({tag, "_start_width"}, 32'(cnn_start), 0);
    check({tag, "_start_count"}, starts - s0, 1);
    check({tag, "_loads"}, loads_run, NW);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_readdata"}, readdata, 0);
    check({tag, "_irq"}, 32'(irq), 0);
    check({tag, "_cnn_load"}, 32'(cnn_load), 0);
    check({tag, "_cnn_data_in"}, cnn_data_in, 0);
    check({tag, "_cnn_start"}, 32'(cnn_start), 0);
    @(negedge clk);
    exp_q.delete();
    m_done    = 1'b0;
    m_ovf     = 1'b0;
    m_result  = '0;
    loads_run = 0;
    rst_n     = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic [DW-1:0] r;
    int            s0;

    rst_n        = 1'b0;
    chipselect   = 1'b0;
    write        = 1'b0;
    read         = 1'b0;
    address      = '0;
    writedata    = '0;
    cnn_done     = 1'b0;
    cnn_data_out = '0;
    m_done       = 1'b0;
    m_ovf        = 1'b0;
    m_result     = '0;
    loads_run    = 0;
    starts       = 0;
    trickle      = 1'b0;
    prev_load    = 1'b0;

    // Power-on reset
    repeat (3) @(negedge clk);
    do_reset("por");

    // Register access table in IDLE with an empty FIFO
    tbl.push_back('{1'b0, 3'd2, 16'h0000, 16'h0008});
    tbl.push_back('{1'b0, 3'd3, 16'h0000, 16'h0000});
    tbl.push_back('{1'b0, 3'd4, 16'h0000, 16'h0000});
    tbl.push_back('{1'b0, 3'd5, 16'h0000, 16'h0000});
    tbl.push_back('{1'b0, 3'd6, 16'h0000, 16'h0000});
    tbl.push_back('{1'b0, 3'd7, 16'h0000, 16'h0000});
    tbl.push_back('{1'b1, 3'd2, 16'hFFFF, 16'h0000});
    tbl.push_back('{1'b1, 3'd3, 16'h1234, 16'h0000});
    tbl.push_back('{1'b1, 3'd4, 16'h00FF, 16'h0000});
    tbl.push_back('{1'b1, 3'd7, 16'hFFFF, 16'h0000});
    tbl.push_back('{1'b1, 3'd1, 16'h0002, 16'h0000});
    tbl.push_back('{1'b0, 3'd3, 16'h0000, 16'h0000});
    tbl.push_back('{1'b0, 3'd4, 16'h0000, 16'h0000});
    tbl.push_back('{1'b1, 3'd1, 16'h0000, 16'h0000});
    tbl.push_back('{1'b0, 3'd2, 16'h0000, 16'h0008});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].is_wr) bus_write(tbl[i].a, tbl[i].d);
      else              read_check($sformatf("tbl%0d_rd%0d", i, tbl[i].a), tbl[i].a, tbl[i].exp);
    end
    repeat (3) @(negedge clk);
    check("readdata_hold", readdata, 16'h0008);

    // Preload 16 words, GO, feed the rest back to back
    for (int i = 1; i <= DEPTH; i++) push_word(DW'(i), 1'b1);
    read_check("t2_status_full", 3'd2, exp_status(1'b0));
    s0 = starts;
    go_run();
    for (int i = DEPTH + 1; i <= NW; i++) push_word(DW'($urandom), 1'b0);
    wait_run("t2", s0);
    read_check("t2_count_wait", 3'd4, 16'(NW));
    read_check("t2_status_wait", 3'd2, exp_status(1'b1));
    pulse_done(16'h0007);
    m_done   = 1'b1;
    m_result = 16'h0007;
    check("t5_irq_set", 32'(irq), 1);
    read_check("t5_result", 3'd3, m_result);
    read_check("t5_status_done", 3'd2, exp_status(1'b0));
    read_check("t2_count_final", 3'd4, 16'(NW));

    // cnn_done outside WAIT is ignored
    pulse_done(DW'($urandom) | 16'h0100);
    read_check("t5_result_idle_done", 3'd3, m_result);
    bus_write(3'd1, 16'h0002);
    m_done = 1'b0;
    check("t5_irq_clr", 32'(irq), 0);
    read_check("t5_status_clr", 3'd2, exp_status(1'b0));

    // Overflow: 17 pushes into a 16-entry FIFO while IDLE
    for (int i = 0; i < DEPTH + 1; i++) push_word(DW'($urandom), 1'b1);
    read_check("t3_status_ovf", 3'd2, exp_status(1'b0));
    bus_write(3'd1, 16'h0002);
    m_ovf = 1'b0;
    read_check("t3_status_clr", 3'd2, exp_status(1'b0));

    // GO while busy, push+pop at full, two excess words, CLR with capture
    s0 = starts;
    go_run();
    push_word(DW'($urandom), 1'b0);
    bus_write(3'd1, 16'h0001);
    bus_read(3'd4, rd);
    check("t6_count_after_busy_go", rd, 2);
    bus_read(3'd2, rd);
    check("t6_busy_no_ovf", rd & 16'h0005, 16'h0001);
    for (int i = 0; i < NW - DEPTH - 1 + 2; i++) push_word(DW'($urandom), 1'b0);
    wait_run("t6", s0);
    r            = DW'($urandom);
    cnn_done     = 1'b1;
    cnn_data_out = r;
    chipselect   = 1'b1;
    write        = 1'b1;
    address      = 3'd1;
    writedata    = 16'h0002;
    @(negedge clk);
    cnn_done     = 1'b0;
    chipselect   = 1'b0;
    write        = 1'b0;
    m_done       = 1'b1;
    m_result     = r;
    check("t6_irq_done_wins", 32'(irq), 1);
    read_check("t6_status_leftover", 3'd2, exp_status(1'b0));
    read_check("t6_result", 3'd3, m_result);
    read_check("t6_count", 3'd4, 16'(NW));

    // Reset mid-LOAD: two leftover words stream, then the run stalls
    s0 = starts;
    go_run();
    repeat (6) @(negedge clk);
    check("t1_loads_before_reset", loads_run, 2);
    read_check("t1_status_busy", 3'd2, exp_status(1'b1));
    do_reset("t1");
    read_check("t1_status_after", 3'd2, 16'h0008);
    read_check("t1_result_after", 3'd3, 16'h0000);
    read_check("t1_count_after", 3'd4, 16'h0000);
    check("t1_irq_after", 32'(irq), 0);

    // GO with empty FIFO, words trickled one per five cycles
    trickle = 1'b1;
    s0 = starts;
    go_run();
    for (int i = 0; i < NW; i++) begin
      push_word(DW'($urandom), 1'b0);
      repeat (4) @(negedge clk);
    end
    wait_run("t4", s0);
    trickle = 1'b0;
    r = DW'($urandom);
    pulse_done(r);
    m_done   = 1'b1;
    m_result = r;
    read_check("t4_result", 3'd3, m_result);
    read_check("t4_status", 3'd2, exp_status(1'b0));
    repeat (5) @(negedge clk);
    check("t4_total_starts", starts, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
